// File: rtl/dcc_pkg.sv
// dcc_pkg: shared types and constants for the DCC track receiver.
//   dcc_state_e  : packet FSM states (HUNT / DATA / SEP)
//   half_cls_e   : half-bit classification (ONE / ZERO / INVALID)
//   DCC_*        : default half-bit timing (clk cycles) and preamble length
//   pkt_mask     : byte-lane mask for a given data-byte count
package dcc_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_SEP  = 2'd2
    } dcc_state_e;

    typedef enum logic [1:0] {
        HB_ONE     = 2'd0,
        HB_ZERO    = 2'd1,
        HB_INVALID = 2'd2
    } half_cls_e;

    localparam int DCC_ONE_MIN      = 52;
    localparam int DCC_ONE_MAX      = 64;
    localparam int DCC_ZERO_MIN     = 90;
    localparam int DCC_ZERO_MAX     = 10000;
    localparam int DCC_PREAMBLE_MIN = 10;

    // Keeps only the lanes holding data bytes; the error byte and stale
    // bytes from older packets are zeroed.
    function automatic logic [23:0] pkt_mask(input logic [1:0] len);
        case (len)
            2'd1:    return 24'h0000FF;
            2'd2:    return 24'h00FFFF;
            2'd3:    return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/dcc_bit_decoder.sv
// dcc_bit_decoder: turns the raw track polarity into DCC bits.
//   Synchronises track_in (2 flops), optionally majority-filters it
//   (macro DCC_RX_GLITCH_FILTER_EN), times the gap between level changes,
//   classifies each half-bit and pairs equal halves into one bit.
// Ports:
//   clk, reset_n  : clock, async active-low reset
//   track_in      : raw track polarity (asynchronous)
//   bit_valid     : one-cycle pulse, a bit was decoded
//   bit_value     : value of the decoded bit (valid with bit_valid)
//   half_invalid  : one-cycle pulse, an out-of-range half-bit was seen
module dcc_bit_decoder import dcc_pkg::*; #(
    parameter int ONE_MIN  = DCC_ONE_MIN,
    parameter int ONE_MAX  = DCC_ONE_MAX,
    parameter int ZERO_MIN = DCC_ZERO_MIN,
    parameter int ZERO_MAX = DCC_ZERO_MAX
) (
    input  logic clk,
    input  logic reset_n,
    input  logic track_in,
    output logic bit_valid,
    output logic bit_value,
    output logic half_invalid
);

    localparam logic [16:0] ONE_MIN_W  = 17'(ONE_MIN);
    localparam logic [16:0] ONE_MAX_W  = 17'(ONE_MAX);
    localparam logic [16:0] ZERO_MIN_W = 17'(ZERO_MIN);
    localparam logic [16:0] ZERO_MAX_W = 17'(ZERO_MAX);
    localparam logic [15:0] TMO_W      = 16'(ZERO_MAX);

    logic        sync1_q, sync2_q, lvl_prev_q, lvl, edge_det;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] half_len;
    logic        half_evt;
    half_cls_e   cls, first_q, first_d;
    logic        have_q, have_d;
    logic        bit_valid_q, bit_valid_d, bit_value_q, bit_value_d;
    logic        half_inv_q, half_inv_d;

`ifdef DCC_RX_GLITCH_FILTER_EN
    // 2-of-3 vote over the last three synchronised samples: single-cycle
    // pulses never win the vote, and real edges appear two cycles later.
    logic [2:0] hist_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) hist_q <= '0;
        else          hist_q <= {hist_q[1:0], sync2_q};
    assign lvl = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                 (hist_q[1] & hist_q[2]);
`else
    assign lvl = sync2_q;
`endif

    assign edge_det = lvl ^ lvl_prev_q;
    // Counter clears on the edge, so the closing edge sees length-1.
    assign half_len = {1'b0, cnt_q} + 17'd1;
    // Timeout fires once, when the open half has just exceeded ZERO_MAX.
    assign half_evt = edge_det || (cnt_q == TMO_W);

    always_comb begin
        cls = HB_INVALID;
        if (edge_det) begin
            if (half_len >= ONE_MIN_W && half_len <= ONE_MAX_W)
                cls = HB_ONE;
            else if (half_len >= ZERO_MIN_W && half_len <= ZERO_MAX_W)
                cls = HB_ZERO;
        end
    end

    always_comb begin
        cnt_d = edge_det ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
        have_d      = have_q;
        first_d     = first_q;
        bit_valid_d = 1'b0;
        bit_value_d = bit_value_q;
        half_inv_d  = 1'b0;
        if (half_evt) begin
            if (cls == HB_INVALID) begin
                have_d     = 1'b0;
                half_inv_d = 1'b1;
            end else if (have_q && cls == first_q) begin
                have_d      = 1'b0;
                bit_valid_d = 1'b1;
                bit_value_d = (cls == HB_ONE);
            end else begin
                // First half, or a mismatch: this half starts a new pair.
                have_d  = 1'b1;
                first_d = cls;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            lvl_prev_q  <= 1'b0;
            cnt_q       <= '0;
            have_q      <= 1'b0;
            first_q     <= HB_ONE;
            bit_valid_q <= 1'b0;
            bit_value_q <= 1'b0;
            half_inv_q  <= 1'b0;
        end else begin
            sync1_q     <= track_in;
            sync2_q     <= sync1_q;
            lvl_prev_q  <= lvl;
            cnt_q       <= cnt_d;
            have_q      <= have_d;
            first_q     <= first_d;
            bit_valid_q <= bit_valid_d;
            bit_value_q <= bit_value_d;
            half_inv_q  <= half_inv_d;
        end
    end

    assign bit_valid    = bit_valid_q;
    assign bit_value    = bit_value_q;
    assign half_invalid = half_inv_q;

endmodule

// File: rtl/dcc_rx.sv
// dcc_rx: DCC packet receiver. Decodes bits (dcc_bit_decoder), frames
//   preamble / data bytes / separators / end bit, checks the XOR error byte
//   and offers packets on a valid/ready interface.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   track_in              : raw track polarity (asynchronous)
//   pkt_valid / pkt_ready : packet handshake
//   pkt_data, pkt_len     : data bytes (first in [7:0]) and count 1..3
//   err_xor, err_frame,
//   overflow              : one-cycle error pulses
// Optional macro: DCC_RX_GLITCH_FILTER_EN (majority filter in the decoder).
module dcc_rx import dcc_pkg::*; #(
    parameter int ONE_MIN      = DCC_ONE_MIN,
    parameter int ONE_MAX      = DCC_ONE_MAX,
    parameter int ZERO_MIN     = DCC_ZERO_MIN,
    parameter int ZERO_MAX     = DCC_ZERO_MAX,
    parameter int PREAMBLE_MIN = DCC_PREAMBLE_MIN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        track_in,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [23:0] pkt_data,
    output logic [1:0]  pkt_len,
    output logic        err_xor,
    output logic        err_frame,
    output logic        overflow
);

    localparam logic [7:0] PRE_W = 8'(PREAMBLE_MIN);

    logic bit_valid, bit_value, half_invalid;

    dcc_bit_decoder #(
        .ONE_MIN(ONE_MIN), .ONE_MAX(ONE_MAX),
        .ZERO_MIN(ZERO_MIN), .ZERO_MAX(ZERO_MAX)
    ) u_dec (
        .clk(clk), .reset_n(reset_n), .track_in(track_in),
        .bit_valid(bit_valid), .bit_value(bit_value), .half_invalid(half_invalid)
    );

    dcc_state_e  state_q, state_d;
    logic [7:0]  ones_cnt_q, ones_cnt_d, xor_q, xor_d;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [23:0] bytes_q, bytes_d, pkt_data_q, pkt_data_d;
    logic [1:0]  pkt_len_q, pkt_len_d, done_len;
    logic        pkt_valid_q, pkt_valid_d, err_xor_q, err_xor_d;
    logic        err_frame_q, err_frame_d, overflow_q, overflow_d;
    logic        pkt_done;
    logic [7:0]  new_byte;

    assign new_byte = {shift_q, bit_value};
    assign done_len = 2'(byte_cnt_q - 3'd1);

    // State register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= ST_HUNT;
        else          state_q <= state_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (half_invalid) begin
            state_d = ST_HUNT;
        end else if (bit_valid) begin
            case (state_q)
                ST_HUNT: if (!bit_value && ones_cnt_q >= PRE_W) state_d = ST_DATA;
                ST_DATA: if (bit_cnt_q == 3'd7)
                             state_d = (byte_cnt_q == 3'd4) ? ST_HUNT : ST_SEP;
                ST_SEP:  state_d = bit_value ? ST_HUNT : ST_DATA;
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        ones_cnt_d  = ones_cnt_q;
        xor_d       = xor_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        bytes_d     = bytes_q;
        pkt_valid_d = pkt_valid_q;
        pkt_data_d  = pkt_data_q;
        pkt_len_d   = pkt_len_q;
        err_xor_d   = 1'b0;
        err_frame_d = 1'b0;
        overflow_d  = 1'b0;
        pkt_done    = 1'b0;

        if (half_invalid) begin
            ones_cnt_d  = 8'd0;
            err_frame_d = (state_q != ST_HUNT);
        end else if (bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (bit_value) begin
                        if (ones_cnt_q != 8'hFF) ones_cnt_d = ones_cnt_q + 8'd1;
                    end else begin
                        ones_cnt_d = 8'd0;
                        if (ones_cnt_q >= PRE_W) begin
                            byte_cnt_d = 3'd0;
                            bit_cnt_d  = 3'd0;
                            xor_d      = 8'd0;
                        end
                    end
                end
                ST_DATA: begin
                    shift_d   = new_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == 3'd4) begin
                            // Fifth byte: longer than any legal packet.
                            err_frame_d = 1'b1;
                            ones_cnt_d  = 8'd0;
                        end else begin
                            // Lane 3 can only ever hold the error byte,
                            // which is already folded into xor_acc.
                            case (byte_cnt_q[1:0])
                                2'd0:    bytes_d[7:0]   = new_byte;
                                2'd1:    bytes_d[15:8]  = new_byte;
                                2'd2:    bytes_d[23:16] = new_byte;
                                default: ;
                            endcase
                            xor_d      = xor_q ^ new_byte;
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                end
                ST_SEP: begin
                    bit_cnt_d = 3'd0;
                    if (bit_value) begin
                        if (byte_cnt_q == 3'd1) begin
                            err_frame_d = 1'b1;
                            ones_cnt_d  = 8'd0;
                        end else begin
                            ones_cnt_d = 8'd1;
                            if (xor_q != 8'd0) err_xor_d = 1'b1;
                            else               pkt_done  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (pkt_valid_q && pkt_ready) pkt_valid_d = 1'b0;
        if (pkt_done) begin
            if (pkt_valid_q && !pkt_ready) begin
                overflow_d = 1'b1;
            end else begin
                pkt_valid_d = 1'b1;
                pkt_len_d   = done_len;
                pkt_data_d  = bytes_q & pkt_mask(done_len);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones_cnt_q  <= '0;
            xor_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            bytes_q     <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_len_q   <= '0;
            err_xor_q   <= 1'b0;
            err_frame_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            ones_cnt_q  <= ones_cnt_d;
            xor_q       <= xor_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            bytes_q     <= bytes_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_len_q   <= pkt_len_d;
            err_xor_q   <= err_xor_d;
            err_frame_q <= err_frame_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_data  = pkt_data_q;
    assign pkt_len   = pkt_len_q;
    assign err_xor   = err_xor_q;
    assign err_frame = err_frame_q;
    assign overflow  = overflow_q;

endmodule
